baud_gen_frac: RTL and testbench

- Runtime-programmable fractional baud-rate generator; successor to the fixed integer divider in the UART clocking path.
- Produces an oversample tick, a mid-bit sample strobe and a bit-rate tick from one system clock.
- Uses an integer divisor plus a FRAC_W-bit fractional accumulator, so the average oversample period is DIV_INT + DIV_FRAC/2^FRAC_W clk cycles.
- Feeds the UART TX and RX state machines; RX uses `restart` to phase-align to a start-bit edge.

---
 rtl/baud_gen_frac.sv | 158 +++++++++++++++
 tb/tb_baud_gen_frac.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator for the UART clocking path.
// A down-counter reloads with DIV_INT (+1 whenever the FRAC_W-bit accumulator
// carries), which makes the average oversample period DIV_INT + DIV_FRAC/2^FRAC_W.
// A phase counter derives the mid-bit strobe and the bit tick from os_tick.
// New divisors go into a pending register. They are applied only on a reload
// edge, or when the generator is idle, so the period in progress is never cut short.
module baud_gen_frac #(
    parameter int DIV_INT_W      = 16,
    parameter int FRAC_W         = 4,
    parameter int OVERSAMPLE     = 16,
    parameter int RESET_DIV_INT  = 6,
    parameter int RESET_DIV_FRAC = 13
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          restart,
    input  logic                          cfg_wr,
    input  logic [DIV_INT_W-1:0]          cfg_div_int,
    input  logic [FRAC_W-1:0]             cfg_div_frac,
    output logic                          cfg_busy,
    output logic                          os_tick,
    output logic                          mid_tick,
    output logic                          bit_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] os_phase
);

    localparam int PH_W = $clog2(OVERSAMPLE);
    localparam logic [PH_W-1:0] PH_LAST    = PH_W'(OVERSAMPLE - 1);
    localparam logic [PH_W-1:0] PH_MID_PRE = PH_W'(OVERSAMPLE / 2 - 1);

    // A divisor of zero would never produce a tick, so it is promoted to one.
    function automatic logic [DIV_INT_W-1:0] fix_div(input logic [DIV_INT_W-1:0] d);
        if (d == {DIV_INT_W{1'b0}}) begin
            fix_div = DIV_INT_W'(1);
        end else begin
            fix_div = d;
        end
    endfunction

    logic [DIV_INT_W-1:0] act_int_r;
    logic [FRAC_W-1:0]    act_frac_r;
    logic [DIV_INT_W-1:0] pend_int_r;
    logic [FRAC_W-1:0]    pend_frac_r;
    logic                 busy_r;
    logic [DIV_INT_W-1:0] cnt_r;
    logic [FRAC_W-1:0]    acc_r;
    logic [PH_W-1:0]      phase_r;
    logic                 os_tick_r;
    logic                 mid_tick_r;
    logic                 bit_tick_r;

    logic [DIV_INT_W-1:0] sel_int_s;
    logic [FRAC_W-1:0]    sel_frac_s;
    logic [FRAC_W:0]      sum_s;
    logic [DIV_INT_W-1:0] reload_s;
    logic [DIV_INT_W-1:0] restart_cnt_s;

    // Pick the divisor for a reload: same-cycle write, else pending, else active.
    always_comb begin
        sel_int_s  = act_int_r;
        sel_frac_s = act_frac_r;
        if (cfg_wr) begin
            sel_int_s  = fix_div(cfg_div_int);
            sel_frac_s = cfg_div_frac;
        end else if (busy_r) begin
            sel_int_s  = pend_int_r;
            sel_frac_s = pend_frac_r;
        end else begin
            sel_int_s  = act_int_r;
            sel_frac_s = act_frac_r;
        end
    end

    // Accumulate the fraction and stretch the next period by the carry.
    // sel_int_s is at least one, so the reload value cannot overflow.
    always_comb begin
        sum_s         = {1'b0, acc_r} + {1'b0, sel_frac_s};
        reload_s      = (sel_int_s - DIV_INT_W'(1))
                        + {{(DIV_INT_W-1){1'b0}}, sum_s[FRAC_W]};
        restart_cnt_s = sel_int_s - DIV_INT_W'(1);
    end

    // Divisor registers, period counter, accumulator, phase and tick outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            act_int_r   <= DIV_INT_W'(RESET_DIV_INT);
            act_frac_r  <= FRAC_W'(RESET_DIV_FRAC);
            pend_int_r  <= DIV_INT_W'(RESET_DIV_INT);
            pend_frac_r <= FRAC_W'(RESET_DIV_FRAC);
            busy_r      <= 1'b0;
            cnt_r       <= DIV_INT_W'(RESET_DIV_INT - 1);
            acc_r       <= {FRAC_W{1'b0}};
            phase_r     <= {PH_W{1'b0}};
            os_tick_r   <= 1'b0;
            mid_tick_r  <= 1'b0;
            bit_tick_r  <= 1'b0;
        end else if (restart) begin
            act_int_r   <= sel_int_s;
            act_frac_r  <= sel_frac_s;
            pend_int_r  <= sel_int_s;
            pend_frac_r <= sel_frac_s;
            busy_r      <= 1'b0;
            cnt_r       <= restart_cnt_s;
            acc_r       <= {FRAC_W{1'b0}};
            phase_r     <= {PH_W{1'b0}};
            os_tick_r   <= 1'b0;
            mid_tick_r  <= 1'b0;
            bit_tick_r  <= 1'b0;
        end else if (!enable) begin
            os_tick_r  <= 1'b0;
            mid_tick_r <= 1'b0;
            bit_tick_r <= 1'b0;
            if (cfg_wr) begin
                pend_int_r  <= fix_div(cfg_div_int);
                pend_frac_r <= cfg_div_frac;
                busy_r      <= 1'b1;
            end else if (busy_r) begin
                act_int_r  <= pend_int_r;
                act_frac_r <= pend_frac_r;
                busy_r     <= 1'b0;
            end else begin
                busy_r <= 1'b0;
            end
        end else if (cnt_r != {DIV_INT_W{1'b0}}) begin
            cnt_r      <= cnt_r - DIV_INT_W'(1);
            os_tick_r  <= 1'b0;
            mid_tick_r <= 1'b0;
            bit_tick_r <= 1'b0;
            if (cfg_wr) begin
                pend_int_r  <= fix_div(cfg_div_int);
                pend_frac_r <= cfg_div_frac;
                busy_r      <= 1'b1;
            end else begin
                busy_r <= busy_r;
            end
        end else begin
            act_int_r   <= sel_int_s;
            act_frac_r  <= sel_frac_s;
            pend_int_r  <= sel_int_s;
            pend_frac_r <= sel_frac_s;
            busy_r      <= 1'b0;
            acc_r       <= sum_s[FRAC_W-1:0];
            cnt_r       <= reload_s;
            phase_r     <= phase_r + PH_W'(1);
            os_tick_r   <= 1'b1;
            mid_tick_r  <= (phase_r == PH_MID_PRE);
            bit_tick_r  <= (phase_r == PH_LAST);
        end
    end

    assign cfg_busy = busy_r;
    assign os_tick  = os_tick_r;
    assign mid_tick = mid_tick_r;
    assign bit_tick = bit_tick_r;
    assign os_phase = phase_r;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: a divisor table, hand-written timing sequences and
// randomized enable/restart traffic checked against a closed-form tick-time model.
module tb_baud_gen_frac;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        restart;
    logic        cfg_wr;
    logic [15:0] cfg_div_int;
    logic [3:0]  cfg_div_frac;
    logic        cfg_busy;
    logic        os_tick;
    logic        mid_tick;
    logic        bit_tick;
    logic [3:0]  os_phase;

    baud_gen_frac dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .restart      (restart),
        .cfg_wr       (cfg_wr),
        .cfg_div_int  (cfg_div_int),
        .cfg_div_frac (cfg_div_frac),
        .cfg_busy     (cfg_busy),
        .os_tick      (os_tick),
        .mid_tick     (mid_tick),
        .bit_tick     (bit_tick),
        .os_phase     (os_phase)
    );

    always #5 clk = ~clk;

    int nvec  = 0;
    int nfail = 0;
    int tt   [32];
    int tb_b [32];
    int tb_m [32];

    typedef struct {
        logic [15:0] di;
        logic [3:0]  df;
        int          p1;
        int          p2;
        int          p3;
        int          t16;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run with the current inputs until n ticks are seen; tt[] holds the edge index of each.
    task automatic measure(input int n, input string name);
        int e;
        int got;
        e   = 0;
        got = 0;
        while (got < n && e < 2000) begin
            step();
            e++;
            if (os_tick === 1'b1) begin
                tt[got]   = e;
                tb_b[got] = int'(bit_tick);
                tb_m[got] = int'(mid_tick);
                got++;
            end
        end
        if (got < n) chk({name, " timeout"}, got, n);
    endtask

    // Ticks counted from phase 0: mid on the 8th, bit on the 16th, nothing else.
    task automatic bm_chk(input int n, input string name);
        int ok;
        ok = 1;
        for (int i = 0; i < n; i++) begin
            if (tb_b[i] != ((i % 16) == 15 ? 1 : 0)) ok = 0;
            if (tb_m[i] != ((i % 16) == 7 ? 1 : 0)) ok = 0;
        end
        chk({name, " bit/mid"}, ok, 1);
    endtask

    task automatic cfg_idle(input logic [15:0] di, input logic [3:0] df);
        enable       = 1'b0;
        cfg_wr       = 1'b1;
        cfg_div_int  = di;
        cfg_div_frac = df;
        step();
        cfg_wr = 1'b0;
        step();
    endtask

    task automatic do_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    // Default divisor 6/13 from a fresh phase: first tick at 6, then 16 periods summing to 109.
    task automatic default_seq(input string name);
        measure(17, name);
        chk({name, " first"}, tt[0], 6);
        chk({name, " sum16"}, tt[16] - tt[0], 109);
        bm_chk(17, name);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [8];
        int   nh;
        int   k;
        int   n;
        int   dv;
        int   fr;
        int   tgt;
        logic [6:0] exp_o;

        tbl[0] = '{16'd6,  4'd0,  6,  6,  6,  96};
        tbl[1] = '{16'd6,  4'd8,  6,  6,  7,  103};
        tbl[2] = '{16'd1,  4'd0,  1,  1,  1,  16};
        tbl[3] = '{16'd0,  4'd0,  1,  1,  1,  16};
        tbl[4] = '{16'd10, 4'd0,  10, 10, 10, 160};
        tbl[5] = '{16'd6,  4'd13, 6,  6,  7,  108};
        tbl[6] = '{16'd3,  4'd15, 3,  3,  4,  62};
        tbl[7] = '{16'd1,  4'd15, 1,  1,  2,  30};

        reset        = 1'b0;
        enable       = 1'b0;
        restart      = 1'b0;
        cfg_wr       = 1'b0;
        cfg_div_int  = 16'd0;
        cfg_div_frac = 4'd0;
        repeat (3) step();
        chk("reset outputs", {os_tick, mid_tick, bit_tick, cfg_busy, os_phase}, 32'd0);

        // Release from reset straight into running with the default divisor.
        reset  = 1'b1;
        enable = 1'b1;
        default_seq("post-reset");

        // Divisor table: configure while idle, realign, then time the first ticks.
        for (int i = 0; i < 8; i++) begin
            string nm;
            nm = $sformatf("tbl%0d", i);
            cfg_idle(tbl[i].di, tbl[i].df);
            chk({nm, " busy clear"}, cfg_busy, 0);
            enable = 1'b1;
            do_restart();
            measure(16, nm);
            chk({nm, " p1"}, tt[0], tbl[i].p1);
            chk({nm, " p2"}, tt[1] - tt[0], tbl[i].p2);
            chk({nm, " p3"}, tt[2] - tt[1], tbl[i].p3);
            chk({nm, " t16"}, tt[15], tbl[i].t16);
            bm_chk(16, nm);
        end

        // Enable drop for 5 cycles stretches the period by 5 and holds the phase.
        cfg_idle(16'd6, 4'd0);
        enable = 1'b1;
        do_restart();
        measure(1, "hold pre");
        chk("hold pre", tt[0], 6);
        step();
        step();
        enable = 1'b0;
        nh = 0;
        repeat (5) begin
            step();
            if (os_tick !== 1'b0) nh++;
        end
        chk("hold no tick", nh, 0);
        chk("hold phase", os_phase, 1);
        enable = 1'b1;
        measure(1, "hold resume");
        chk("hold resume", tt[0], 4);

        // Restart mid-bit: no tick on that edge, phase 0, next tick div_int later.
        repeat (3) step();
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("restart tick", os_tick, 0);
        chk("restart phase", os_phase, 0);
        measure(1, "restart next");
        chk("restart next", tt[0], 6);
        chk("restart phase after", os_phase, 1);

        // Write while running: busy until the old period ends, then the new period.
        step();
        step();
        cfg_wr       = 1'b1;
        cfg_div_int  = 16'd10;
        cfg_div_frac = 4'd0;
        step();
        cfg_wr = 1'b0;
        chk("run cfg busy", cfg_busy, 1);
        measure(1, "run cfg old");
        chk("run cfg old", tt[0], 3);
        chk("run cfg busy clr", cfg_busy, 0);
        measure(1, "run cfg new");
        chk("run cfg new", tt[0], 10);

        // Write on the counter-zero edge is used for that very reload.
        repeat (9) step();
        cfg_wr       = 1'b1;
        cfg_div_int  = 16'd7;
        step();
        cfg_wr = 1'b0;
        chk("zero cfg tick", os_tick, 1);
        chk("zero cfg busy", cfg_busy, 0);
        measure(1, "zero cfg new");
        chk("zero cfg new", tt[0], 7);

        // Two writes before application: only the last one takes effect.
        step();
        cfg_wr       = 1'b1;
        cfg_div_int  = 16'd9;
        step();
        cfg_div_int  = 16'd4;
        step();
        cfg_wr = 1'b0;
        measure(1, "two wr old");
        chk("two wr old", tt[0], 4);
        measure(1, "two wr new");
        chk("two wr new", tt[0], 4);

        // Asynchronous reset between edges clears outputs without a clock edge.
        chk("async pre tick", os_tick, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async outputs", {os_tick, mid_tick, bit_tick, cfg_busy, os_phase}, 32'd0);
        step();
        step();
        reset = 1'b1;
        do_restart();
        default_seq("post-async");

        // Random enable/restart traffic against the closed-form model:
        // the n-th tick after a realign lands on enabled edge n*div + floor((n-1)*frac/16).
        for (int r = 0; r < 6; r++) begin
            cfg_div_int  = 16'($urandom_range(0, 9));
            cfg_div_frac = 4'($urandom_range(0, 15));
            dv = (cfg_div_int == 16'd0) ? 1 : int'(cfg_div_int);
            fr = int'(cfg_div_frac);
            cfg_idle(cfg_div_int, cfg_div_frac);
            do_restart();
            k = 0;
            n = 0;
            for (int c = 0; c < 300; c++) begin
                enable  = ($urandom_range(0, 3) != 0);
                restart = ($urandom_range(0, 49) == 0);
                step();
                exp_o = 7'd0;
                if (restart) begin
                    k = 0;
                    n = 0;
                end else if (enable) begin
                    k++;
                    tgt = (n + 1) * dv + (n * fr) / 16;
                    if (k == tgt) begin
                        n++;
                        exp_o[6] = 1'b1;
                        exp_o[5] = ((n % 16) == 8);
                        exp_o[4] = ((n % 16) == 0);
                    end
                end
                exp_o[3:0] = 4'(n % 16);
                chk($sformatf("rand r%0d c%0d {tick,mid,bit,phase}", r, c),
                    {os_tick, mid_tick, bit_tick, os_phase}, 32'(exp_o));
            end
            restart = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
